regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Write-side companion of the register file. It merges two result producers onto the register file's single write port (we/a3/wd3). The in-order writeback stage has absolute priority; the long-latency unit (mul/div/load-miss) handshakes results into a small ordered queue. The queue drains whenever the writeback stage is idle. Pending-write lookups let the hazard unit stall readers of registers still waiting in the queue.

## Interface
- N, 5: register address width
- M, 32: data width
- DEPTH, 4: queue entries, power of two, ≥2

- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high
- wb_we  input  1  writeback-stage write request; never stalled
- wb_rd  input  N  writeback destination
- wb_data  input  M  writeback data
- ll_valid  input  1  long-latency result valid
- ll_rd  input  N  long-latency destination
- ll_data  input  M  long-latency data
- ll_ready  output  1  queue can accept; reset 1
- rf_we  output  1  register file write enable; reset 0
- rf_a3  output  N  register file write address; reset 0
- rf_wd3  output  M  register file write data; reset 0
- q1, q2  input  N  hazard-unit query addresses
- pend1, pend2  output  1  a live queued write targets q1/q2; reset 0
- count  output  $clog2(DEPTH+1)  occupied entries, live and killed; reset 0

## Operation
- Entry = {live, rd, data}. Circular buffer with head/tail pointers and count.
- Accept: ll_valid && ll_ready. ll_ready = (count != DEPTH).
  - ll_rd==0 → accepted, not enqueued.
  - ll_rd equals wb_rd while wb_we && wb_rd!=0 in the same cycle → accepted, not enqueued. The long-latency op is older and the pipeline write supersedes it.
  - Otherwise → push {1, ll_rd, ll_data} at tail.
- Kill: wb_we && wb_rd!=0 clears live on every queued entry whose rd==wb_rd. This is the WAW rule: a younger pipeline write is never overwritten by an older queued result.
- Write port, combinational from state and inputs:
  - wb_we && wb_rd!=0 → rf_we=1, rf_a3=wb_rd, rf_wd3=wb_data.
  - else head present and live → write head entry, pop.
  - else rf_we=0, rf_a3=0, rf_wd3=0.
- Dead head (live=0) pops in any cycle without writing, including cycles where the pipeline is writing.
- Writes to x0 never reach rf_we.
- pend1 = (q1!=0) && any live entry with rd==q1. pend2 likewise. Purely combinational over current state. Same-cycle pushes are not reflected.
- Simultaneous push and pop: count unchanged, pointers both advance.
- Reset mid-operation: all entries discarded (live cleared, pointers and count zero). No write is issued in the reset cycle.

## Timing
- Writeback path: zero latency, same-cycle rf_we. The register file commits on negedge.
- Queued result: earliest write is the cycle after acceptance, then further delayed one cycle per consecutive pipeline write.
- ll_ready depends only on registered count. No combinational path from ll_valid.
- Full queue with a pop this cycle: ll_ready stays 0 this cycle and rises the next.
- Drain order is strictly FIFO among live entries. Throughput is one write per cycle.

## Configuration
- REGFILE_WB_BYPASS_EN defined: when count==0, wb_we==0 and ll_valid with ll_rd!=0, the result is driven straight to rf_we/rf_a3/rf_wd3 in the same cycle and not enqueued.
- Undefined: every accepted long-latency result passes through the queue, giving a minimum one-cycle latency.
- The pending and kill rules are identical in both builds.

## Structure
- Shared package regfile_pkg:
  - typedef wbq_entry_t {logic live; logic [N-1:0] rd; logic [M-1:0] data}
  - localparam defaults REG_ADDR_W=5, REG_DATA_W=32, WBQ_DEPTH=4
- No sub-module. Kill and pending lookup need parallel access to every entry, so the storage lives inline as an entry array.

## Test plan
- Reset, then idle: ll_ready=1, rf_we=0, count=0, pend1=pend2=0.
- ll push {rd=5, 0x11}, {rd=6, 0x22}, {rd=7, 0x33} with wb_we=1 for 2 cycles after → pipeline writes first. Then the rf sees 5←0x11, 6←0x22, 7←0x33 on consecutive cycles.
- Fill 4 entries with wb_we held 1 (rd=9) → ll_ready=0, count=4, pend1=1 for q1=10 (a queued rd). Drop wb_we → ll_ready returns 1 the cycle after the first pop.
- Queue {rd=4, 0xAA}, then pipeline writes rd=4, 0xBB → entry killed. rf[4] ends 0xBB, and the dead entry pops with rf_we=0.
- Same cycle: ll {rd=3, 0x1} and wb {rd=3, 0x2} → only 0x2 written, count stays 0. Separately, ll_rd=0 → accepted, no write.
- Assert reset with 3 entries queued → next cycle count=0, no writes. Then, with REGFILE_WB_BYPASS_EN, ll {rd=8, 0x5} into an empty queue → rf_we in the same cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default widths for the register-file write arbiter.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned WBQ_DEPTH  = 4;

  typedef struct packed {
    logic                  live;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_DATA_W-1:0] data;
  } wbq_entry_t;

endpackage

// File: rtl/regfile_write_arbiter.sv
// Merges the writeback stage and a queued long-latency producer onto the single rf write port.
// Optional same-cycle bypass of an empty queue: define REGFILE_WB_BYPASS_EN.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned N     = REG_ADDR_W,
  parameter int unsigned M     = REG_DATA_W,
  parameter int unsigned DEPTH = WBQ_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wb_we,
  input  logic [N-1:0]                 wb_rd,
  input  logic [M-1:0]                 wb_data,
  input  logic                         ll_valid,
  input  logic [N-1:0]                 ll_rd,
  input  logic [M-1:0]                 ll_data,
  output logic                         ll_ready,
  output logic                         rf_we,
  output logic [N-1:0]                 rf_a3,
  output logic [M-1:0]                 rf_wd3,
  input  logic [N-1:0]                 q1,
  input  logic [N-1:0]                 q2,
  output logic                         pend1,
  output logic                         pend2,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  wbq_entry_t       q [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  wbq_entry_t head_e;
  logic       wb_act;
  logic       head_live;
  logic       head_dead;
  logic       accept;
  logic       bypass;
  logic       pop;
  logic       push;

  // Arbitration: pipeline first, then (optional) bypass, then live queue head.
  always_comb begin
    wb_act    = wb_we && (wb_rd != '0);
    head_e    = q[head];
    head_live = (count != '0) && head_e.live;
    head_dead = (count != '0) && !head_e.live;
    ll_ready  = (count != CNT_W'(DEPTH));
    accept    = ll_valid && ll_ready;
`ifdef REGFILE_WB_BYPASS_EN
    bypass    = (count == '0) && !wb_we && ll_valid && (ll_rd != '0);
`else
    bypass    = 1'b0;
`endif
    pop       = head_dead || (head_live && !wb_act);
    // A same-cycle pipeline write to the same rd supersedes the older result.
    push      = accept && (ll_rd != '0) && !(wb_act && (ll_rd == wb_rd)) && !bypass;

    rf_we  = 1'b0;
    rf_a3  = '0;
    rf_wd3 = '0;
    if (!reset) begin
      if (wb_act) begin
        rf_we  = 1'b1;
        rf_a3  = wb_rd;
        rf_wd3 = wb_data;
      end else if (bypass) begin
        rf_we  = 1'b1;
        rf_a3  = ll_rd;
        rf_wd3 = ll_data;
      end else if (head_live) begin
        rf_we  = 1'b1;
        rf_a3  = N'(head_e.rd);
        rf_wd3 = M'(head_e.data);
      end
    end
  end

  // Pending lookup; popped and killed entries have live cleared, so live alone marks validity.
  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (q[i].live && (q1 != '0) && (N'(q[i].rd) == q1)) pend1 = 1'b1;
      if (q[i].live && (q2 != '0) && (N'(q[i].rd) == q2)) pend2 = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) q[i].live <= 1'b0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (wb_act && (N'(q[i].rd) == wb_rd)) q[i].live <= 1'b0;
      end
      if (pop) begin
        q[head].live <= 1'b0;
        head         <= head + PTR_W'(1);
      end
      if (push) begin
        q[tail] <= '{live: 1'b1, rd: REG_ADDR_W'(ll_rd), data: REG_DATA_W'(ll_data)};
        tail    <= tail + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed table, hand sequences, random vs queue model.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we, ll_valid;
  logic [4:0]  wb_rd, ll_rd, q1, q2, rf_a3;
  logic [31:0] wb_data, ll_data, rf_wd3;
  logic        ll_ready, rf_we, pend1, pend2;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  regfile_write_arbiter dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ll_valid(ll_valid), .ll_rd(ll_rd), .ll_data(ll_data), .ll_ready(ll_ready),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd3(rf_wd3),
    .q1(q1), .q2(q2), .pend1(pend1), .pend2(pend2), .count(count)
  );

  always #5 clk = ~clk;

  // Output tuple: {we, a3, wd3, ready, count, pend1, pend2}
  logic [43:0] act, mexp;

  typedef struct {
    logic live;
    logic [4:0] rd;
    logic [31:0] data;
  } ment_t;
  ment_t mq[$];

  // Reference: an ordered list of results; the writer takes the oldest, dead ones vanish.
  task automatic model_step();
    int n;
    logic wb_act, byp, m_we, p1, p2;
    logic [4:0] a3;
    logic [31:0] wd;
    n = mq.size();
    wb_act = wb_we && (wb_rd != 0);
    byp = 1'b0;
`ifdef REGFILE_WB_BYPASS_EN
    byp = (n == 0) && !wb_we && ll_valid && (ll_rd != 0);
`endif
    p1 = 1'b0; p2 = 1'b0;
    foreach (mq[i]) begin
      if (mq[i].live && q1 != 0 && mq[i].rd == q1) p1 = 1'b1;
      if (mq[i].live && q2 != 0 && mq[i].rd == q2) p2 = 1'b1;
    end
    m_we = 1'b0; a3 = 0; wd = 0;
    if (!reset) begin
      if (wb_act) begin m_we = 1; a3 = wb_rd; wd = wb_data; end
      else if (byp) begin m_we = 1; a3 = ll_rd; wd = ll_data; end
      else if (n > 0 && mq[0].live) begin m_we = 1; a3 = mq[0].rd; wd = mq[0].data; end
    end
    mexp = {m_we, a3, wd, 1'(n != 4), 3'(n), p1, p2};
    if (reset) begin
      mq.delete();
    end else begin
      if (n > 0 && (!mq[0].live || !wb_act)) void'(mq.pop_front());
      if (wb_act) foreach (mq[i]) if (mq[i].rd == wb_rd) mq[i].live = 1'b0;
      if (ll_valid && n != 4 && ll_rd != 0 && !(wb_act && ll_rd == wb_rd) && !byp)
        mq.push_back('{live: 1'b1, rd: ll_rd, data: ll_data});
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    model_step();
    act = {rf_we, rf_a3, rf_wd3, ll_ready, count, pend1, pend2};
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic drive(input logic wwe, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic [4:0] a1, input logic [4:0] a2);
    wb_we = wwe; wb_rd = wrd; wb_data = wd;
    ll_valid = lv; ll_rd = lrd; ll_data = ld;
    q1 = a1; q2 = a2;
  endtask

  typedef struct {
    logic wwe; logic [4:0] wrd; logic [31:0] wd;
    logic lv;  logic [4:0] lrd; logic [31:0] ld;
    logic [4:0] a1, a2;
    logic [43:0] exp;
  } vec_t;
  vec_t tbl[29];

  function automatic vec_t mk(logic wwe, logic [4:0] wrd, logic [31:0] wd,
                              logic lv, logic [4:0] lrd, logic [31:0] ld,
                              logic [4:0] a1, logic [4:0] a2,
                              logic ewe, logic [4:0] ea3, logic [31:0] ewd,
                              logic erdy, logic [2:0] ecnt, logic ep1, logic ep2);
    vec_t v;
    v.wwe = wwe; v.wrd = wrd; v.wd = wd; v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.a1 = a1; v.a2 = a2;
    v.exp = {ewe, ea3, ewd, erdy, ecnt, ep1, ep2};
    return v;
  endfunction

  initial begin
    // Push behind pipeline writes, then drain in order.
    tbl[0]  = mk(0, 0, 0,      0, 0, 0,       0, 0,   0, 0, 0,        1, 0, 0, 0);
    tbl[1]  = mk(1, 20, 'hA0,  1, 5, 'h11,    5, 0,   1, 20, 'hA0,    1, 0, 0, 0);
    tbl[2]  = mk(1, 21, 'hA1,  1, 6, 'h22,    5, 6,   1, 21, 'hA1,    1, 1, 1, 0);
    tbl[3]  = mk(1, 22, 'hA2,  1, 7, 'h33,    6, 7,   1, 22, 'hA2,    1, 2, 1, 0);
    tbl[4]  = mk(1, 23, 'hA3,  0, 0, 0,       7, 0,   1, 23, 'hA3,    1, 3, 1, 0);
    tbl[5]  = mk(1, 24, 'hA4,  0, 0, 0,       0, 0,   1, 24, 'hA4,    1, 3, 0, 0);
    tbl[6]  = mk(0, 0, 0,      0, 0, 0,       5, 6,   1, 5, 'h11,     1, 3, 1, 1);
    tbl[7]  = mk(0, 0, 0,      0, 0, 0,       5, 6,   1, 6, 'h22,     1, 2, 0, 1);
    tbl[8]  = mk(0, 0, 0,      0, 0, 0,       7, 0,   1, 7, 'h33,     1, 1, 1, 0);
    tbl[9]  = mk(0, 0, 0,      0, 0, 0,       7, 0,   0, 0, 0,        1, 0, 0, 0);
    // Fill to full, then release.
    tbl[10] = mk(1, 9, 'hB0,   1, 10, 'h100,  10, 0,  1, 9, 'hB0,     1, 0, 0, 0);
    tbl[11] = mk(1, 9, 'hB1,   1, 11, 'h101,  10, 0,  1, 9, 'hB1,     1, 1, 1, 0);
    tbl[12] = mk(1, 9, 'hB2,   1, 12, 'h102,  10, 11, 1, 9, 'hB2,     1, 2, 1, 1);
    tbl[13] = mk(1, 9, 'hB3,   1, 13, 'h103,  10, 12, 1, 9, 'hB3,     1, 3, 1, 1);
    tbl[14] = mk(1, 9, 'hB4,   1, 14, 'h104,  10, 14, 1, 9, 'hB4,     0, 4, 1, 0);
    tbl[15] = mk(0, 0, 0,      1, 14, 'h104,  10, 13, 1, 10, 'h100,   0, 4, 1, 1);
    tbl[16] = mk(0, 0, 0,      1, 14, 'h104,  10, 11, 1, 11, 'h101,   1, 3, 0, 1);
    tbl[17] = mk(0, 0, 0,      0, 0, 0,       14, 12, 1, 12, 'h102,   1, 3, 1, 1);
    tbl[18] = mk(0, 0, 0,      0, 0, 0,       14, 12, 1, 13, 'h103,   1, 2, 1, 0);
    tbl[19] = mk(0, 0, 0,      0, 0, 0,       14, 0,  1, 14, 'h104,   1, 1, 1, 0);
    tbl[20] = mk(0, 0, 0,      0, 0, 0,       14, 0,  0, 0, 0,        1, 0, 0, 0);
    // Kill of a queued entry by a younger pipeline write.
    tbl[21] = mk(1, 20, 'hC0,  1, 4, 'hAA,    4, 0,   1, 20, 'hC0,    1, 0, 0, 0);
    tbl[22] = mk(1, 4, 'hBB,   0, 0, 0,       4, 0,   1, 4, 'hBB,     1, 1, 1, 0);
    tbl[23] = mk(0, 0, 0,      0, 0, 0,       4, 0,   0, 0, 0,        1, 1, 0, 0);
    tbl[24] = mk(0, 0, 0,      0, 0, 0,       4, 0,   0, 0, 0,        1, 0, 0, 0);
    // Same-cycle collision, and a write to x0.
    tbl[25] = mk(1, 3, 'h2,    1, 3, 'h1,     3, 0,   1, 3, 'h2,      1, 0, 0, 0);
    tbl[26] = mk(0, 0, 0,      0, 0, 0,       3, 0,   0, 0, 0,        1, 0, 0, 0);
    tbl[27] = mk(0, 0, 0,      1, 0, 'h55,    0, 0,   0, 0, 0,        1, 0, 0, 0);
    tbl[28] = mk(0, 0, 0,      0, 0, 0,       0, 0,   0, 0, 0,        1, 0, 0, 0);

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    cyc();
    reset = 1'b0;

    for (int i = 0; i < 29; i++) begin
      drive(tbl[i].wwe, tbl[i].wrd, tbl[i].wd, tbl[i].lv, tbl[i].lrd, tbl[i].ld, tbl[i].a1, tbl[i].a2);
      cyc();
      chk($sformatf("vec%0d", i), 64'(act), 64'(tbl[i].exp));
    end

    // Reset with three entries queued.
    drive(1, 20, 'hD0, 1, 1, 'hD1, 0, 0); cyc();
    drive(1, 21, 'hD0, 1, 2, 'hD2, 0, 0); cyc();
    drive(1, 22, 'hD0, 1, 3, 'hD3, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 0, 1, 2);
    reset = 1'b1; cyc();
    chk("rst_cycle", 64'({act[43], act[4:2]}), 64'({1'b0, 3'd3}));
    reset = 1'b0; cyc();
    chk("rst_after", 64'(act), 64'({1'b0, 5'd0, 32'd0, 1'b1, 3'd0, 1'b0, 1'b0}));
    cyc();
    chk("rst_idle", 64'(act[43]), 64'(0));

    // Empty-queue long-latency result.
    drive(0, 0, 0, 1, 8, 'h5, 8, 0); cyc();
`ifdef REGFILE_WB_BYPASS_EN
    chk("byp_c0", 64'(act[43:6]), 64'({1'b1, 5'd8, 32'h5}));
    drive(0, 0, 0, 0, 0, 0, 8, 0); cyc();
    chk("byp_c1", 64'(act), 64'({1'b0, 5'd0, 32'd0, 1'b1, 3'd0, 1'b0, 1'b0}));
`else
    chk("byp_c0", 64'(act[43:6]), 64'({1'b0, 5'd0, 32'd0}));
    drive(0, 0, 0, 0, 0, 0, 8, 0); cyc();
    chk("byp_c1", 64'(act), 64'({1'b1, 5'd8, 32'h5, 1'b1, 3'd1, 1'b1, 1'b0}));
`endif

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 79) == 0);
      drive(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      cyc();
      chk($sformatf("rnd%0d", i), 64'(act), 64'(mexp));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
